// File: rtl/screen_sequencer.sv
// screen_sequencer
//   Chooses which full-screen renderer drives the VGA output: start screen,
//   game field, player-1-won or player-2-won. Game events are latched as a
//   pending request and applied only on a frame edge, which is the rising
//   edge of vblnk_in, so the visible picture never tears. A win screen goes
//   back to START after WIN_FRAMES frame edges or on a button press.
//
// Ports
//   clk        pixel clock
//   rst        asynchronous reset, active-low
//   start_btn  start/continue button (level, synchronised, debounced)
//   p1_win     one-cycle pulse: player 1 won
//   p2_win     one-cycle pulse: player 2 won
//   vblnk_in   vertical blank of the aligned draw-stage timing
//   rgb_start  pixel from the start-screen stage
//   rgb_game   pixel from the game-field stage
//   rgb_p1     pixel from the player-1-won stage
//   rgb_p2     pixel from the player-2-won stage
//   rgb_out    selected pixel, registered (1-cycle latency)
//   screen     current state: 0=START 1=GAME 2=P1_WON 3=P2_WON
//   game_en    high only in GAME
//   frame_cnt  frame edges elapsed in the current win state
module screen_sequencer #(
    parameter int unsigned WIN_FRAMES = 600,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_btn,
    input  logic             p1_win,
    input  logic             p2_win,
    input  logic             vblnk_in,
    input  logic [11:0]      rgb_start,
    input  logic [11:0]      rgb_game,
    input  logic [11:0]      rgb_p1,
    input  logic [11:0]      rgb_p2,
    output logic [11:0]      rgb_out,
    output logic [1:0]       screen,
    output logic             game_en,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        S_START  = 2'd0,
        S_GAME   = 2'd1,
        S_P1_WON = 2'd2,
        S_P2_WON = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        R_NONE,
        R_GAME,
        R_P1,
        R_P2,
        R_START
    } req_t;

    state_t           state;
    state_t           state_nxt;
    req_t             req;
    req_t             req_eff;
    req_t             req_nxt;
    logic             vblnk_q;
    logic             start_q;
    logic             fe;
    logic             bp;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_nxt;
    logic [11:0]      rgb_sel;

    always_comb begin
        fe      = vblnk_in & ~vblnk_q;
        bp      = start_btn & ~start_q;
        cnt_inc = frame_cnt + CNT_W'(1);

        // A request already pending wins over anything arriving this cycle;
        // otherwise this cycle's event is merged in so that an event
        // coinciding with the frame edge is applied at that same edge.
        req_eff = req;
        if (req == R_NONE) begin
            case (state)
                S_START: if (bp) req_eff = R_GAME;
                S_GAME: begin
                    if (p1_win)      req_eff = R_P1;
                    else if (p2_win) req_eff = R_P2;
                end
                default: if (bp) req_eff = R_START;
            endcase
        end

        state_nxt = state;
        req_nxt   = req_eff;
        cnt_nxt   = frame_cnt;
        if (fe) begin
            req_nxt = R_NONE;
            if (req_eff != R_NONE) begin
                cnt_nxt = '0;
                case (req_eff)
                    R_GAME:  state_nxt = S_GAME;
                    R_P1:    state_nxt = S_P1_WON;
                    R_P2:    state_nxt = S_P2_WON;
                    default: state_nxt = S_START;
                endcase
            end else if (state == S_P1_WON || state == S_P2_WON) begin
                if (cnt_inc == CNT_W'(WIN_FRAMES)) begin
                    state_nxt = S_START;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
        end

        case (state)
            S_START:  rgb_sel = rgb_start;
            S_GAME:   rgb_sel = rgb_game;
            S_P1_WON: rgb_sel = rgb_p1;
            default:  rgb_sel = rgb_p2;
        endcase
    end

    // screen/game_en are loaded from the next state so they change on the
    // same edge as the state register; rgb_out uses the present state, so
    // the new screen's pixels appear one cycle after the frame edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_START;
            req       <= R_NONE;
            frame_cnt <= '0;
            vblnk_q   <= 1'b0;
            start_q   <= 1'b0;
            rgb_out   <= '0;
            screen    <= 2'd0;
            game_en   <= 1'b0;
        end else begin
            state     <= state_nxt;
            req       <= req_nxt;
            frame_cnt <= cnt_nxt;
            vblnk_q   <= vblnk_in;
            start_q   <= start_btn;
            rgb_out   <= rgb_sel;
            screen    <= state_nxt;
            game_en   <= (state_nxt == S_GAME);
        end
    end

endmodule

// File: tb/tb_screen_sequencer.sv
module tb_screen_sequencer;

    localparam int WIN = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_btn = 1'b0;
    logic        p1_win = 1'b0;
    logic        p2_win = 1'b0;
    logic        vblnk_in = 1'b0;
    logic [11:0] rgb_start = 12'h00F;
    logic [11:0] rgb_game  = 12'h0F0;
    logic [11:0] rgb_p1    = 12'hFF0;
    logic [11:0] rgb_p2    = 12'hF00;
    logic [11:0] rgb_out;
    logic [1:0]  screen;
    logic        game_en;
    logic [3:0]  frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    screen_sequencer #(.WIN_FRAMES(WIN), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .p1_win(p1_win),
        .p2_win(p2_win), .vblnk_in(vblnk_in), .rgb_start(rgb_start),
        .rgb_game(rgb_game), .rgb_p1(rgb_p1), .rgb_p2(rgb_p2),
        .rgb_out(rgb_out), .screen(screen), .game_en(game_en),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the screen is a number 0..3, the pending request is
    // the target screen number or -1 when nothing is pending.
    int          m_screen;
    int          m_req;
    int          m_cnt;
    bit          m_vq;
    bit          m_sq;
    logic [11:0] m_rgb;

    task automatic model_reset();
        m_screen = 0; m_req = -1; m_cnt = 0; m_vq = 0; m_sq = 0; m_rgb = 12'h000;
    endtask

    task automatic model_step();
        logic [11:0] pix [4];
        bit new_frame = vblnk_in && !m_vq;
        bit press     = start_btn && !m_sq;
        pix[0] = rgb_start; pix[1] = rgb_game; pix[2] = rgb_p1; pix[3] = rgb_p2;
        if (m_req < 0) begin
            if (m_screen == 0 && press)          m_req = 1;
            else if (m_screen == 1 && p1_win)    m_req = 2;
            else if (m_screen == 1 && p2_win)    m_req = 3;
            else if (m_screen >= 2 && press)     m_req = 0;
        end
        m_rgb = pix[m_screen];
        if (new_frame) begin
            if (m_req >= 0) begin
                m_screen = m_req; m_req = -1; m_cnt = 0;
            end else if (m_screen >= 2) begin
                m_cnt++;
                if (m_cnt == WIN) begin m_screen = 0; m_cnt = 0; end
            end
        end
        m_vq = vblnk_in;
        m_sq = start_btn;
    endtask

    // One clock: model consumes the inputs of this cycle, DUT is sampled 1ns
    // after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        vblnk_in = 1'b1; tick();
        vblnk_in = 1'b0; tick();
    endtask

    task automatic press();
        start_btn = 1'b1; tick();
        start_btn = 1'b0; tick();
    endtask

    task automatic go_game();
        press(); frame();
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        model_reset();
        #2;
        n_checks++;
        if ({rgb_out, screen, game_en, frame_cnt} !== {12'h000, 2'd0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got rgb=%h screen=%0d game_en=%b cnt=%0d, want 000/0/0/0",
                     rgb_out, screen, game_en, frame_cnt);
        end
        @(posedge clk); #3 rst = 1'b1; #3;
        tick();
        n_checks++;
        if (rgb_out !== 12'h00F) begin
            n_fail++;
            $display("FAIL first_pixel: got %h want 00F", rgb_out);
        end
    endtask

    task automatic test_start();
        start_btn = 1'b1; tick(); start_btn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (screen !== 2'd0) begin
                n_fail++;
                $display("FAIL start_wait: cycle %0d screen=%0d want 0", i, screen);
            end
        end
        vblnk_in = 1'b1; tick();
        n_checks++;
        if ({screen, game_en, rgb_out} !== {2'd1, 1'b1, 12'h00F}) begin
            n_fail++;
            $display("FAIL start_edge: got screen=%0d game_en=%b rgb=%h want 1/1/00F",
                     screen, game_en, rgb_out);
        end
        vblnk_in = 1'b0; tick();
        n_checks++;
        if (rgb_out !== 12'h0F0) begin
            n_fail++;
            $display("FAIL start_rgb: got %h want 0F0", rgb_out);
        end
    endtask

    task automatic test_both_wins();
        p1_win = 1'b1; p2_win = 1'b1; tick();
        p1_win = 1'b0; p2_win = 1'b0;
        vblnk_in = 1'b1; tick();
        n_checks++;
        if ({screen, game_en} !== {2'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL both_wins_screen: got screen=%0d game_en=%b want 2/0", screen, game_en);
        end
        vblnk_in = 1'b0; tick();
        n_checks++;
        if ({rgb_out, screen, frame_cnt} !== {12'hFF0, 2'd2, 4'd0}) begin
            n_fail++;
            $display("FAIL both_wins_rgb: got rgb=%h screen=%0d cnt=%0d want FF0/2/0",
                     rgb_out, screen, frame_cnt);
        end
    endtask

    task automatic test_timeout();
        press(); frame();                       // P1_WON -> START
        n_checks++;
        if (screen !== 2'd0) begin
            n_fail++;
            $display("FAIL win_button_return: got screen=%0d want 0", screen);
        end
        go_game();
        p2_win = 1'b1; tick(); p2_win = 1'b0;
        frame();
        n_checks++;
        if ({screen, frame_cnt} !== {2'd3, 4'd0}) begin
            n_fail++;
            $display("FAIL enter_p2: got screen=%0d cnt=%0d want 3/0", screen, frame_cnt);
        end
        for (int f = 1; f <= WIN; f++) begin
            logic [5:0] want;
            frame();
            want = (f < WIN) ? {2'd3, 4'(f)} : {2'd0, 4'd0};
            n_checks++;
            if ({screen, frame_cnt} !== want) begin
                n_fail++;
                $display("FAIL timeout_frame%0d: got screen=%0d cnt=%0d want screen=%0d cnt=%0d",
                         f, screen, frame_cnt, want[5:4], want[3:0]);
            end
        end
    endtask

    task automatic test_button_hold();
        go_game();
        p2_win = 1'b1; tick(); p2_win = 1'b0;
        frame(); frame();
        n_checks++;
        if ({screen, frame_cnt} !== {2'd3, 4'd1}) begin
            n_fail++;
            $display("FAIL hold_setup: got screen=%0d cnt=%0d want 3/1", screen, frame_cnt);
        end
        start_btn = 1'b1;
        repeat (100) tick();
        frame();
        n_checks++;
        if ({screen, frame_cnt} !== {2'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL hold_return: got screen=%0d cnt=%0d want 0/0", screen, frame_cnt);
        end
        frame();
        n_checks++;
        if ({screen, game_en} !== {2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_no_regame: got screen=%0d game_en=%b want 0/0", screen, game_en);
        end
        start_btn = 1'b0; tick();
    endtask

    task automatic test_coincident();
        go_game();
        p2_win = 1'b1; vblnk_in = 1'b1; tick();
        p2_win = 1'b0; vblnk_in = 1'b0;
        n_checks++;
        if (screen !== 2'd3) begin
            n_fail++;
            $display("FAIL coincident: got screen=%0d want 3", screen);
        end
        tick();
        press(); frame();
    endtask

    task automatic test_async_reset();
        go_game();
        rgb_game = 12'hABC;
        tick(); tick();
        n_checks++;
        if (rgb_out !== 12'hABC) begin
            n_fail++;
            $display("FAIL game_pixel: got %h want ABC", rgb_out);
        end
        #2 rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({rgb_out, screen, game_en} !== {12'h000, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got rgb=%h screen=%0d game_en=%b want 000/0/0",
                     rgb_out, screen, game_en);
        end
        @(posedge clk); #3 rst = 1'b1; #3;
        p1_win = 1'b1; tick(); p1_win = 1'b0;
        frame();
        n_checks++;
        if ({screen, game_en} !== {2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL win_after_reset: got screen=%0d game_en=%b want 0/0", screen, game_en);
        end
        rgb_game = 12'h0F0;
    endtask

    task automatic test_random();
        int vb_left = 5;
        for (int c = 0; c < 4000; c++) begin
            if (vb_left == 0) begin
                vblnk_in = ~vblnk_in;
                vb_left  = vblnk_in ? $urandom_range(1, 3) : $urandom_range(2, 12);
            end else begin
                vb_left--;
            end
            if ($urandom_range(0, 9) == 0) start_btn = ~start_btn;
            p1_win    = ($urandom_range(0, 11) == 0);
            p2_win    = ($urandom_range(0, 11) == 0);
            rgb_start = 12'($urandom);
            rgb_game  = 12'($urandom);
            rgb_p1    = 12'($urandom);
            rgb_p2    = 12'($urandom);
            tick();
            n_checks++;
            if ({rgb_out, screen, game_en, frame_cnt} !==
                {m_rgb, 2'(m_screen), (m_screen == 1), 4'(m_cnt)}) begin
                n_fail++;
                $display("FAIL random_c%0d: got rgb=%h scr=%0d en=%b cnt=%0d want rgb=%h scr=%0d cnt=%0d",
                         c, rgb_out, screen, game_en, frame_cnt, m_rgb, m_screen, m_cnt);
            end
        end
        p1_win = 1'b0; p2_win = 1'b0; start_btn = 1'b0; vblnk_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_both_wins();
        test_timeout();
        test_button_hold();
        test_coincident();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
